// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared types and helpers for the load/store unit.
//   size_e       : access size encoding carried on req_size (2'b11 is illegal)
//   lsu_state_e  : load_store_unit FSM states
//   is_misaligned: true when a size/offset pair cannot be served by one word access
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_e;

  // The illegal size encoding is folded into the misaligned case so the FSM
  // has a single error path.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      SZ_WORD: is_misaligned = (offset != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
//   Purely combinational little-endian byte-lane logic for 32-bit words.
//   rd         in  : word read from memory
//   wdata      in  : right-justified store data
//   offset     in  : byte offset within the word (addr[1:0])
//   size       in  : access size (size_e encoding)
//   is_signed  in  : sign-extend loads when 1, zero-extend when 0
//   load_data  out : selected lane(s) of rd, extended to 32 bits
//   merge_data out : rd with the target lane(s) replaced by store data
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd[8*offset +: 8];
  assign half_sel = offset[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    load_data = '0;
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
      SZ_WORD: load_data = rd;
      default: load_data = '0;
    endcase
  end

  // Each lane decides independently whether it keeps the memory byte or takes
  // store data. A half store feeds wdata[7:0] to its low lane and wdata[15:8]
  // to its high lane, hence the gi%2 lane index.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;

      assign hit = (size == SZ_WORD) ||
                   ((size == SZ_BYTE) && (offset == LANE)) ||
                   ((size == SZ_HALF) && (offset[1] == LANE[1]));

      assign src = (size == SZ_BYTE) ? wdata[7:0] :
                   (size == SZ_HALF) ? wdata[8*(gi%2) +: 8] :
                                       wdata[8*gi +: 8];

      assign merge_data[8*gi +: 8] = hit ? src : rd[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the word-wide data-memory port. Takes one load/store at
//   a time, performs sub-word stores as read-modify-write, extends sub-word
//   loads, and rejects misaligned/illegal requests without touching memory.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_signed, req_addr,
//   req_wdata               : request fields (byte address, right-justified data)
//   resp_valid              : one-cycle completion pulse
//   resp_rdata, resp_err    : load data (0 for stores/errors), error flag
//   MemRead, MemWrite       : memory enables (never both high)
//   Address, WD, RD         : word index, write data, combinational read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [DEPTH+1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               resp_valid,
  output logic [WIDTH-1:0]   resp_rdata,
  output logic               resp_err,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [DEPTH-1:0]   Address,
  output logic [WIDTH-1:0]   WD,
  input  logic [WIDTH-1:0]   RD
);

  lsu_state_e         state_reg;
  logic [1:0]         size_reg;
  logic               signed_reg;
  logic [DEPTH+1:0]   addr_reg;
  logic [WIDTH-1:0]   wdata_reg;
  logic [WIDTH-1:0]   merge_reg;
  logic               req_ready_reg;
  logic               resp_valid_reg;
  logic [WIDTH-1:0]   resp_rdata_reg;
  logic               resp_err_reg;
  logic               mem_read_reg;
  logic               mem_write_reg;

  logic [WIDTH-1:0]   load_data;
  logic [WIDTH-1:0]   merge_data;

  lsu_lane_align u_lane_align (
    .rd         (RD),
    .wdata      (wdata_reg),
    .offset     (addr_reg[1:0]),
    .size       (size_reg),
    .is_signed  (signed_reg),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign MemRead    = mem_read_reg;
  assign MemWrite   = mem_write_reg;
  assign Address    = addr_reg[DEPTH+1:2];
  // merge_reg is only non-zero while in WRITE, so WD idles at 0.
  assign WD         = merge_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      size_reg       <= '0;
      signed_reg     <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      merge_reg      <= '0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready_reg) begin
            size_reg      <= req_size;
            signed_reg    <= req_signed;
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
            req_ready_reg <= 1'b0;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= '0;
            end else if (!req_we) begin
              state_reg    <= READ;
              mem_read_reg <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state_reg     <= WRITE;
              mem_write_reg <= 1'b1;
              merge_reg     <= req_wdata;
            end else begin
              state_reg    <= RMW_READ;
              mem_read_reg <= 1'b1;
            end
          end
        end
        READ: begin
          state_reg      <= RESP;
          mem_read_reg   <= 1'b0;
          resp_valid_reg <= 1'b1;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= load_data;
        end
        RMW_READ: begin
          state_reg     <= WRITE;
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b1;
          merge_reg     <= merge_data;
        end
        WRITE: begin
          state_reg      <= RESP;
          mem_write_reg  <= 1'b0;
          merge_reg      <= '0;
          resp_valid_reg <= 1'b1;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= '0;
        end
        RESP: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= '0;
          req_ready_reg  <= 1'b1;
        end
        default: begin
          state_reg      <= IDLE;
          mem_read_reg   <= 1'b0;
          mem_write_reg  <= 1'b0;
          merge_reg      <= '0;
          resp_valid_reg <= 1'b0;
          req_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [4:0]  Address;
  logic [31:0] WD;
  logic [31:0] RD;

  load_store_unit #(.WIDTH(32), .DEPTH(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .WD         (WD),
    .RD         (RD)
  );

  always #5 clk = ~clk;

  // Word-wide memory responder; a fixed junk pattern stands in for the
  // undriven bus when MemRead is low.
  logic [31:0] mem [32];
  always @(posedge clk) if (MemWrite) mem[Address] <= WD;
  assign RD = MemRead ? mem[Address] : 32'h5A5A_5A5A;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [6:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } req_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_req(input req_t r);
    req_we     = r.we;
    req_size   = r.sz;
    req_signed = r.sg;
    req_addr   = r.a;
    req_wdata  = r.wd;
  endtask

  // Called at a negedge while the unit is idle; returns at the negedge after
  // the response, with the unit back in IDLE.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [6:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int exp_rdc, input int exp_wrc, input logic [31:0] exp_wd);
    int          rdc;
    int          wrc;
    logic [31:0] wd_seen;
    exp_t        e;
    bit          done;
    chk1({tag, "/ready"}, req_ready, 1'b1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    sb_q.push_back('{exp_rd, exp_err, exp_lat});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rdc = 0;
    wrc = 0;
    wd_seen = '0;
    done = 1'b0;
    for (int cyc = 1; cyc <= 8 && !done; cyc++) begin
      @(negedge clk);
      if (MemRead === 1'b1) rdc++;
      if (MemWrite === 1'b1) begin
        wrc++;
        wd_seen = WD;
      end
      chk1({tag, "/both_en"}, MemRead & MemWrite, 1'b0);
      chk1({tag, "/busy"}, req_ready, 1'b0);
      if (resp_valid === 1'b1) begin
        chkint({tag, "/sb_depth"}, sb_q.size(), 1);
        e = sb_q.pop_front();
        chk32({tag, "/rdata"}, resp_rdata, e.rdata);
        chk1({tag, "/err"}, resp_err, e.err);
        chkint({tag, "/latency"}, cyc, e.lat);
        done = 1'b1;
      end
    end
    total++;
    assert (done) else begin
      bad++;
      $error("FAIL %s/timeout observed=no_resp expected=resp_valid", tag);
      sb_q.delete();
    end
    chkint({tag, "/rd_cycles"}, rdc, exp_rdc);
    chkint({tag, "/wr_cycles"}, wrc, exp_wrc);
    if (exp_wrc > 0) chk32({tag, "/wd"}, wd_seen, exp_wd);
    @(negedge clk);
    $display("txn %s we=%0b size=%0d addr=%h -> rdata=%h err=%0b rd=%0d wr=%0d", tag, we, sz, a,
             exp_rd, exp_err, rdc, wrc);
  endtask

  req_t stream[4];

  initial begin
    int   idx;
    int   nresp;
    exp_t e;

    // Reset held across a couple of edges, then released at a negedge.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk1("rst/ready", req_ready, 1'b1);
    chk1("rst/resp_valid", resp_valid, 1'b0);
    chk32("rst/resp_rdata", resp_rdata, 32'h0);
    chk1("rst/resp_err", resp_err, 1'b0);
    chk1("rst/memread", MemRead, 1'b0);
    chk1("rst/memwrite", MemWrite, 1'b0);
    chk32("rst/address", {27'h0, Address}, 32'h0);
    chk32("rst/wd", WD, 32'h0);
    @(negedge clk);

    // Word store, loads of every flavour, sub-word stores, errors.
    do_req("sw_dead",  1, 2'b10, 0, 7'h08, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 32'hDEADBEEF);
    do_req("lw_dead",  0, 2'b10, 0, 7'h08, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0, 32'h0);
    do_req("sw_80ff",  1, 2'b10, 0, 7'h08, 32'h80FF7F01, 32'h0, 0, 2, 0, 1, 32'h80FF7F01);
    do_req("lb_0a",    0, 2'b00, 1, 7'h0A, 32'h0, 32'hFFFFFFFF, 0, 2, 1, 0, 32'h0);
    do_req("lbu_0b",   0, 2'b00, 0, 7'h0B, 32'h0, 32'h00000080, 0, 2, 1, 0, 32'h0);
    do_req("lh_0a",    0, 2'b01, 1, 7'h0A, 32'h0, 32'hFFFF80FF, 0, 2, 1, 0, 32'h0);
    do_req("lbu_09",   0, 2'b00, 0, 7'h09, 32'h0, 32'h0000007F, 0, 2, 1, 0, 32'h0);
    do_req("lw_80ff",  0, 2'b10, 0, 7'h08, 32'h0, 32'h80FF7F01, 0, 2, 1, 0, 32'h0);
    do_req("sw_1122",  1, 2'b10, 0, 7'h08, 32'h11223344, 32'h0, 0, 2, 0, 1, 32'h11223344);
    do_req("sb_09",    1, 2'b00, 0, 7'h09, 32'h000000AB, 32'h0, 0, 3, 1, 1, 32'h1122AB44);
    do_req("lw_after_sb", 0, 2'b10, 0, 7'h08, 32'h0, 32'h1122AB44, 0, 2, 1, 0, 32'h0);
    do_req("sh_0a",    1, 2'b01, 0, 7'h0A, 32'h1234BEEF, 32'h0, 0, 3, 1, 1, 32'hBEEFAB44);
    do_req("lhu_0a",   0, 2'b01, 0, 7'h0A, 32'h0, 32'h0000BEEF, 0, 2, 1, 0, 32'h0);
    do_req("lh_08",    0, 2'b01, 1, 7'h08, 32'h0, 32'hFFFFAB44, 0, 2, 1, 0, 32'h0);
    do_req("lb_09",    0, 2'b00, 1, 7'h09, 32'h0, 32'hFFFFFFAB, 0, 2, 1, 0, 32'h0);
    do_req("sh_err03", 1, 2'b01, 0, 7'h03, 32'h0000FFFF, 32'h0, 1, 1, 0, 0, 32'h0);
    do_req("lw_err06", 0, 2'b10, 0, 7'h06, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
    do_req("sz3_err",  0, 2'b11, 0, 7'h00, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
    do_req("lw_kept",  0, 2'b10, 0, 7'h08, 32'h0, 32'hBEEFAB44, 0, 2, 1, 0, 32'h0);

    // Back-to-back with req_valid held high: each request accepted once.
    stream[0] = '{1'b1, 2'b10, 1'b0, 7'h0C, 32'hCAFEF00D, 32'h0, 1'b0};
    stream[1] = '{1'b0, 2'b10, 1'b0, 7'h0C, 32'h0, 32'hCAFEF00D, 1'b0};
    stream[2] = '{1'b0, 2'b01, 1'b1, 7'h0D, 32'h0, 32'h0, 1'b1};
    stream[3] = '{1'b0, 2'b00, 1'b0, 7'h0F, 32'h0, 32'h000000CA, 1'b0};
    idx = 0;
    nresp = 0;
    apply_req(stream[0]);
    req_valid = 1'b1;
    for (int c = 0; c < 60 && (idx < 4 || sb_q.size() > 0); c++) begin
      if (req_ready === 1'b1 && idx < 4) begin
        sb_q.push_back('{stream[idx].rd, stream[idx].err, 0});
        @(posedge clk);
        #1;
        idx++;
        if (idx < 4) apply_req(stream[idx]);
        else req_valid = 1'b0;
      end
      @(negedge clk);
      if (MemRead === 1'b1 || MemWrite === 1'b1 || resp_valid === 1'b1)
        chk1("stream/busy", req_ready, 1'b0);
      if (resp_valid === 1'b1) begin
        total++;
        assert (sb_q.size() > 0) else begin
          bad++;
          $error("FAIL stream/extra_resp observed=resp_valid expected=no_resp");
        end
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk32("stream/rdata", resp_rdata, e.rdata);
          chk1("stream/err", resp_err, e.err);
          $display("txn stream#%0d rdata=%h err=%0b", nresp, resp_rdata, resp_err);
        end
        nresp++;
      end
    end
    req_valid = 1'b0;
    chkint("stream/accepted", idx, 4);
    chkint("stream/responses", nresp, 4);
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk1("stream/no_dup", resp_valid, 1'b0);
    end

    // Reset asserted during WRITE, before the write edge.
    do_req("sw_1111", 1, 2'b10, 0, 7'h10, 32'h11111111, 32'h0, 0, 2, 0, 1, 32'h11111111);
    chk1("abort/ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 7'h10;
    req_wdata = 32'h22222222;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk1("abort/in_write", MemWrite, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("abort/memwrite_drop", MemWrite, 1'b0);
    chk32("abort/wd_drop", WD, 32'h0);
    chk1("abort/no_resp", resp_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      chk1("abort/no_resp_after", resp_valid, 1'b0);
      @(negedge clk);
    end
    $display("txn abort sw addr=10 data=22222222 -> reset during WRITE");
    do_req("lw_old", 0, 2'b10, 0, 7'h10, 32'h0, 32'h11111111, 0, 2, 1, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
